// File: rtl/switch_debouncer.sv
// Switch input conditioner: each raw switch bit is synchronized with two flops, then debounced on
// its own channel. Outputs are a clean level plus registered one-cycle rise/fall strobes.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1, r_sync2;
  logic [WIDTH-1:0] r_clean, r_rise, r_fall;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [WIDTH-1:0] w_clean_d, w_rise_d, w_fall_d;
  logic [CNT_W-1:0] w_cnt_d [WIDTH];

  // The counter only runs while the synchronized bit disagrees with the clean level;
  // any agreement throws away the partial count.
  always_comb begin
    w_clean_d = r_clean;
    w_rise_d  = '0;
    w_fall_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cnt_d[i] = r_cnt[i];
      if (r_sync2[i] == r_clean[i]) begin
        w_cnt_d[i] = '0;
      end else if (r_cnt[i] == CntMax) begin
        w_clean_d[i] = r_sync2[i];
        w_cnt_d[i]   = '0;
        w_rise_d[i]  = r_sync2[i];
        w_fall_d[i]  = ~r_sync2[i];
      end else begin
        w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_clean   <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= sw_in;
      r_sync2   <= r_sync1;
      r_clean   <= w_clean_d;
      r_rise    <= w_rise_d;
      r_fall    <= w_fall_d;
      r_changed <= |(w_rise_d | w_fall_d);
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  assign sw_clean   = r_clean;
  assign sw_rise    = r_rise;
  assign sw_fall    = r_fall;
  assign sw_changed = r_changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (DEBOUNCE_CYCLES=4): expected output snapshots are queued
// with a due cycle when stimulus is applied and checked when that cycle arrives.
module tb_switch_debouncer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEB   = 4;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_clean, sw_rise, sw_fall;
  logic             sw_changed;

  typedef struct {
    int          due;
    logic [7:0]  clean;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic        chg;
    string       tag;
  } exp_t;

  exp_t       sb[$];
  int         cycle;
  int         n_checks;
  int         n_errors;
  logic [24:0] got, want;
  logic [7:0] prev, nv;

  switch_debouncer #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_in     (sw_in),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_at(input int d, input logic [7:0] c, input logic [7:0] r,
                           input logic [7:0] f, input string tag);
    exp_t e;
    e.due   = cycle + d;
    e.clean = c;
    e.rise  = r;
    e.fall  = f;
    e.chg   = |(r | f);
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic quiet(input int from, input int to, input logic [7:0] c, input string tag);
    for (int d = from; d <= to; d++) expect_at(d, c, 8'h00, 8'h00, tag);
  endtask

  // Advance one clock and compare everything due this cycle, 1 ns after the edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cycle++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cycle) begin
          n_checks++;
          got  = {sw_clean, sw_rise, sw_fall, sw_changed};
          want = {sb[i].clean, sb[i].rise, sb[i].fall, sb[i].chg};
          assert (got === want) else begin
            n_errors++;
            $error("FAIL %s @cycle %0d: clean/rise/fall/chg got %h/%h/%h/%b expected %h/%h/%h/%b",
                   sb[i].tag, cycle, got[24:17], got[16:9], got[8:1], got[0],
                   want[24:17], want[16:9], want[8:1], want[0]);
          end
          sb.delete(i);
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    n_checks++;
    got = {sw_clean, sw_rise, sw_fall, sw_changed};
    assert (got === 25'd0) else begin
      n_errors++;
      $error("FAIL %s: outputs got %h expected 0", tag, got);
    end
  endtask

  initial begin
    cycle    = 0;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b1;
    sw_in    = 8'hFF;
    #1 reset_n = 1'b0;
    #2 check_zero("reset_async");

    // Held in reset with switches high: nothing may propagate.
    quiet(1, 2, 8'h00, "reset_hold");
    step(2);
    reset_n = 1'b0;
    reset_n = 1'b1;
    quiet(1, 5, 8'h00, "reset_qual");
    expect_at(6, 8'hFF, 8'hFF, 8'h00, "reset_rise");
    quiet(7, 8, 8'hFF, "reset_after");
    step(8);

    sw_in = 8'h00;
    quiet(1, 5, 8'hFF, "fall_wait");
    expect_at(6, 8'h00, 8'h00, 8'hFF, "fall_all");
    quiet(7, 8, 8'h00, "fall_after");
    step(8);

    sw_in = 8'h01;
    quiet(1, 5, 8'h00, "step_wait");
    expect_at(6, 8'h01, 8'h01, 8'h00, "step_rise");
    quiet(7, 9, 8'h01, "step_after");
    step(9);

    // Three-cycle pulse on bit 3 must be rejected.
    sw_in = 8'h09;
    quiet(1, 12, 8'h01, "glitch_reject");
    step(3);
    sw_in = 8'h01;
    step(9);

    sw_in = 8'h09;
    quiet(1, 5, 8'h01, "hold_wait");
    expect_at(6, 8'h09, 8'h08, 8'h00, "hold_rise");
    quiet(7, 8, 8'h09, "hold_after");
    step(8);

    // Bit 5 toggles every cycle for ten cycles, then settles high.
    quiet(1, 15, 8'h09, "bounce_wait");
    expect_at(16, 8'h29, 8'h20, 8'h00, "bounce_rise");
    quiet(17, 18, 8'h29, "bounce_after");
    for (int i = 0; i < 10; i++) begin
      sw_in = (i % 2 == 0) ? 8'h29 : 8'h09;
      step(1);
    end
    sw_in = 8'h29;
    step(8);

    prev = 8'h29;
    for (int v = 0; v < 256; v += 2) begin
      nv    = 8'(v);
      sw_in = nv;
      quiet(1, 5, prev, "sweep_wait");
      expect_at(6, nv, nv & ~prev, prev & ~nv, "sweep_edge");
      quiet(7, 10, nv, "sweep_after");
      step(10);
      prev = nv;
    end

    // Bit 2 falls; reset lands between edges once its count reaches 2.
    sw_in = 8'hFA;
    quiet(1, 4, 8'hFE, "midcnt_wait");
    step(4);
    #2 reset_n = 1'b0;
    #1 check_zero("midcnt_async");
    quiet(1, 2, 8'h00, "midcnt_hold");
    step(2);
    reset_n = 1'b1;
    quiet(1, 5, 8'h00, "requal_wait");
    expect_at(6, 8'hFA, 8'hFA, 8'h00, "requal_rise");
    quiet(7, 8, 8'hFA, "requal_after");
    step(8);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
